uart_tx_control: RTL and testbench
==================================

# uart_tx_control

- Transmit-side counterpart of the UART receive path.
- Accepts a byte from the host with a write strobe, buffers it, and serialises it onto `TxD` as an asynchronous frame: start bit, 8 data bits LSB first, optional even parity, one stop bit.
- Uses a 16x-oversampling baud tick selectable at run time.
- Sits between the host logic and the line, feeding the receiver's `RxD` on the loopback board.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz; sets the baud divisors.
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `Tx_EN`  in  1: transmitter enable; gates acceptance of new bytes.
- `Tx_WR`  in  1: one-cycle write strobe for `Tx_DATA`.
- `Tx_DATA`  in  8: byte to send.
- `baud_select`  in  3: baud rate index, 0..7.
- `TxD`  out  1: serial line, idle high.
- `Tx_BUSY`  out  1: high from the cycle after acceptance until the frame ends.

## Operation
- Baud table, index to rate: 0=300, 1=1200, 2=4800, 3=9600, 4=19200, 5=38400, 6=57600, 7=115200.
- Divisor is round(`CLK_FREQ`/(16*rate)). At 50 MHz this gives 10417, 2604, 651, 326, 163, 81, 54, 27.
- The tick counter runs 0..divisor-1. `tick` pulses for one cycle at divisor-1.
- Acceptance requires `Tx_WR`=1, `Tx_EN`=1 and state IDLE on the same clock edge. On acceptance:
  - `Tx_DATA` is latched into the shift register.
  - `baud_select` is latched; the divisor stays fixed for the whole frame.
  - The tick counter and the 4-bit oversample counter clear.
- `Tx_WR` while busy or while `Tx_EN`=0 is ignored. There is no queueing and no error flag.
- State machine:
  - IDLE -> START on acceptance.
  - START -> DATA after 16 ticks.
  - DATA -> PARITY after 8 bit-periods of 16 ticks each, with `TxD` = shift[0] and a shift right per bit.
  - PARITY -> STOP after 16 ticks.
  - STOP -> IDLE after 16 ticks.
- `TxD` by state: 1 in IDLE and STOP, 0 in START, XOR of the latched byte in PARITY (even parity).
- Every bit lasts exactly 16*divisor clock cycles.
- Deasserting `Tx_EN` mid-frame does not abort; the current frame completes.
- `baud_select` changes mid-frame take effect only at the next acceptance.

## Timing
- Reset values: `TxD`=1, `Tx_BUSY`=0, state IDLE, all counters 0, shift register 0.
- Reset asserted mid-frame: `TxD` returns to 1 and `Tx_BUSY` to 0 asynchronously. No partial frame resumes.
- Acceptance at edge N: `Tx_BUSY`=1 and `TxD`=0 (start bit) are both registered outputs from edge N+1.
- Frame length L is 11 bits with parity, 10 without. The frame occupies 16*divisor*L cycles from edge N+1.
- `Tx_BUSY` falls on the same edge that ends the stop bit.
- A `Tx_WR` in that same cycle is not accepted. The earliest next acceptance is one cycle later, so back-to-back frames have one idle-high clock cycle between them.
- `TxD` is driven directly from a flop; there are no combinational glitches.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state exists, frame is 11 bits, even parity.
- `UART_TX_PARITY_EN` undefined: DATA -> STOP directly, frame is 10 bits.
- The state encoding is unchanged either way; the PARITY code is simply unreachable.

## Structure
- Package `uart_pkg`:
  - state enum `tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - baud rate table `BAUD_RATES[8]`;
  - function `baud_div(clk_freq, sel)`;
  - constant `OVERSAMPLE = 16`.
- Shared with the receiver, which uses the same table.
- Sub-module `uart_baud_gen`:
  - inputs: `clk`, `reset`, `clear`, latched select;
  - output: `tick`;
  - the receiver reuses it.

## Test plan
- Reset check: hold `reset`=0 with random inputs -> `TxD`=1, `Tx_BUSY`=0. Release, then `Tx_WR` of 8'hA5 with `Tx_EN`=0 -> no frame and `TxD` stays 1.
- Basic frame: `CLK_FREQ`=50e6, `baud_select`=7, `Tx_DATA`=8'hA5 -> `TxD` is 0, 1,0,1,0,0,1,0,1, parity 0, stop 1. Each bit is 432 cycles; `Tx_BUSY` stays high 4752 cycles.
- Parity odd byte: 8'h07 with `UART_TX_PARITY_EN` -> parity bit 1. Without the macro -> stop bit follows bit 7 and `Tx_BUSY` lasts 4320 cycles.
- Collisions: `Tx_WR` 8'h3C mid-frame of 8'hA5, and `baud_select` changed 7 -> 3 mid-frame -> 8'hA5 is sent intact at 432 cycles/bit and 8'h3C is never sent. The next accepted byte uses 5216 cycles/bit.
- Back-to-back: `Tx_WR` held high continuously -> frames separated by exactly one idle-high cycle.
- Mid-frame reset: assert `reset`=0 during data bit 4 -> `TxD`=1 and `Tx_BUSY`=0 immediately. A fresh 8'h81 after release is framed correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, baud table and divisor helper
// shared by the UART transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int OVERSAMPLE = 16;

  localparam int BAUD_RATES [8] = '{
    300, 1200, 4800, 9600,
    19200, 38400, 57600, 115200
  };

  // Rounded clocks per oversample tick.
  function automatic int baud_div(
    input int         clk_freq,
    input logic [2:0] sel
  );
    int r;
    r = OVERSAMPLE * BAUD_RATES[sel];
    return (clk_freq + r / 2) / r;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: 16x oversample tick generator,
// divisor picked from a constant table by sel.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [2:0] sel,
  output logic       tick
);

  localparam int DIV [8] = '{
    baud_div(CLK_FREQ, 3'd0), baud_div(CLK_FREQ, 3'd1),
    baud_div(CLK_FREQ, 3'd2), baud_div(CLK_FREQ, 3'd3),
    baud_div(CLK_FREQ, 3'd4), baud_div(CLK_FREQ, 3'd5),
    baud_div(CLK_FREQ, 3'd6), baud_div(CLK_FREQ, 3'd7)
  };

  localparam int CW = $clog2(DIV[0] + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] top;

  // Table lookup only; no divider in hardware.
  always_comb begin
    top = CW'(DIV[sel] - 1);
  end

  assign tick = (cnt == top);

  // Count 0..divisor-1, restart on clear or wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (clear || tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_control.sv
// uart_tx_control: byte-to-frame serialiser, 16x tick timing.
// Optional even parity bit: define UART_TX_PARITY_EN.
module uart_tx_control
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  input  logic [2:0] baud_select,
  output logic       TxD,
  output logic       Tx_BUSY
);

  tx_state_t  state;
  logic [7:0] shift;
  logic [2:0] sel_q;
  logic [2:0] bit_cnt;
  logic [3:0] os_cnt;
  logic       tick;
  logic       accept;
  logic       bit_end;
`ifdef UART_TX_PARITY_EN
  logic       par;
`endif

  assign accept  = Tx_WR && Tx_EN && (state == IDLE);
  assign bit_end = tick && (os_cnt == 4'(OVERSAMPLE - 1));

  uart_baud_gen #(
    .CLK_FREQ (CLK_FREQ)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .sel   (sel_q),
    .tick  (tick)
  );

  // Frame sequencer with registered line and busy outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      TxD     <= 1'b1;
      Tx_BUSY <= 1'b0;
      shift   <= '0;
      sel_q   <= '0;
      bit_cnt <= '0;
      os_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      if (accept)
        os_cnt <= '0;
      else if (tick)
        os_cnt <= os_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (accept) begin
            shift   <= Tx_DATA;
            sel_q   <= baud_select;
            state   <= START;
            TxD     <= 1'b0;
            Tx_BUSY <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par     <= ^Tx_DATA;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            TxD     <= shift[0];
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              TxD   <= par;
`else
              state <= STOP;
              TxD   <= 1'b1;
`endif
            end else begin
              TxD <= shift[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            TxD   <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            state   <= IDLE;
            Tx_BUSY <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          TxD     <= 1'b1;
          Tx_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_control.sv
// tb_uart_tx_control: directed stimulus, queued expected
// frames, line monitor decoding TxD and Tx_BUSY.
module tb_uart_tx_control;

`ifdef UART_TX_PARITY_EN
  localparam int L = 11;
`else
  localparam int L = 10;
`endif

  logic       clk;
  logic       reset;
  logic       Tx_EN;
  logic       Tx_WR;
  logic [7:0] Tx_DATA;
  logic [2:0] baud_select;
  logic       TxD;
  logic       Tx_BUSY;

  typedef struct {
    logic [7:0] data;
    int         len;
    int         gap;
    bit         abort;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_busy = 0;

  uart_tx_control #(
    .CLK_FREQ (50_000_000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Tx_EN       (Tx_EN),
    .Tx_WR       (Tx_WR),
    .Tx_DATA     (Tx_DATA),
    .baud_select (baud_select),
    .TxD         (TxD),
    .Tx_BUSY     (Tx_BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] req
  );
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, req);
    end
  endtask

  task automatic expect_frame(
    input logic [7:0] d,
    input int         len,
    input int         gap,
    input bit         ab
  );
    exp_t e;
    e.data  = d;
    e.len   = len;
    e.gap   = gap;
    e.abort = ab;
    q.push_back(e);
  endtask

  task automatic write(
    input logic [7:0] d,
    input logic [2:0] s,
    input logic       en
  );
    @(posedge clk);
    #1;
    Tx_DATA     = d;
    baud_select = s;
    Tx_EN       = en;
    Tx_WR       = 1'b1;
    @(posedge clk);
    #1;
    Tx_WR = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain", q.size() + int'(mon_busy), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_txd", TxD, 1);
    check("async_rst_busy", Tx_BUSY, 0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  // Monitor: decode frames on TxD and score them.
  initial begin : monitor
    exp_t        e;
    logic [10:0] bits;
    int          idle_n;
    int          busy_n;
    int          bad;
    int          n;
    bit          ab;
    bit          first;
    idle_n = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        idle_n = 0;
        continue;
      end
      if (TxD === 1'b1) begin
        idle_n++;
        continue;
      end
      if (q.size() == 0) begin
        check("unexpected_frame", 1, 0);
        n = 0;
        while ((Tx_BUSY || !TxD) && n < 100000) begin
          @(negedge clk);
          n++;
        end
        idle_n = 0;
        continue;
      end
      e = q.pop_front();
      mon_busy = 1;
      if (e.gap >= 0)
        check("idle_gap", idle_n, e.gap);
      bits = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++)
        bits[1+i] = e.data[i];
      if (L == 11)
        bits[9] = ^e.data;
      busy_n = 0;
      ab = 0;
      first = 1;
      for (int b = 0; b < L && !ab; b++) begin
        bad = 0;
        for (int c = 0; c < e.len; c++) begin
          if (!first)
            @(negedge clk);
          first = 0;
          if (!reset) begin
            ab = 1;
            break;
          end
          if (TxD !== bits[b])
            bad++;
          if (Tx_BUSY === 1'b1)
            busy_n++;
        end
        if (!ab)
          check($sformatf("bit%0d_%02h", b, e.data),
                bad, 0);
      end
      if (!ab) begin
        @(negedge clk);
        if (Tx_BUSY === 1'b1)
          busy_n++;
        check("busy_len", busy_n, L * e.len);
        idle_n = (TxD === 1'b1) ? 1 : 0;
      end else begin
        idle_n = 0;
      end
      check("abort", int'(ab), int'(e.abort));
      mon_busy = 0;
    end
  end

  // Global time bound.
  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog actual=timeout required=done");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lows;
    int busys;
    int n;
    reset       = 1'b0;
    Tx_EN       = 1'b0;
    Tx_WR       = 1'b0;
    Tx_DATA     = 8'h00;
    baud_select = 3'd7;

    // Reset held with random inputs.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      Tx_EN       = 1'($urandom);
      Tx_WR       = 1'($urandom);
      Tx_DATA     = 8'($urandom);
      baud_select = 3'($urandom);
      #1;
      check("rst_txd", TxD, 1);
      check("rst_busy", Tx_BUSY, 0);
    end
    @(negedge clk);
    Tx_WR = 1'b0;
    Tx_EN = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;

    // Write with enable low is ignored.
    write(8'hA5, 3'd7, 1'b0);
    lows = 0;
    busys = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (TxD !== 1'b1) lows++;
      if (Tx_BUSY !== 1'b0) busys++;
    end
    check("en0_txd_low", lows, 0);
    check("en0_busy", busys, 0);

    // Basic frame at 115200.
    expect_frame(8'hA5, 432, -1, 0);
    write(8'hA5, 3'd7, 1'b1);
    wait_idle(6000);

    // Odd-weight byte; enable dropped mid-frame.
    expect_frame(8'h07, 432, -1, 0);
    write(8'h07, 3'd7, 1'b1);
    repeat (1000) @(posedge clk);
    Tx_EN = 1'b0;
    wait_idle(6000);
    Tx_EN = 1'b1;

    // Collision: write and rate change mid-frame.
    expect_frame(8'hA5, 432, -1, 0);
    write(8'hA5, 3'd7, 1'b1);
    repeat (1000) @(posedge clk);
    write(8'h3C, 3'd3, 1'b1);
    wait_idle(6000);

    // Next byte picks up the 9600 divisor.
    expect_frame(8'h5A, 5216, -1, 1);
    write(8'h5A, 3'd3, 1'b1);
    repeat (2 * 5216 + 100) @(posedge clk);
    pulse_reset();
    repeat (4) @(posedge clk);

    // Back-to-back with Tx_WR held high.
    expect_frame(8'h96, 432, -1, 0);
    expect_frame(8'h69, 432, 1, 0);
    @(posedge clk);
    #1;
    Tx_DATA     = 8'h96;
    baud_select = 3'd7;
    Tx_EN       = 1'b1;
    Tx_WR       = 1'b1;
    n = 0;
    while (Tx_BUSY !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    Tx_DATA = 8'h69;
    n = 0;
    while (Tx_BUSY === 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (Tx_BUSY !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    Tx_WR = 1'b0;
    wait_idle(12000);

    // Reset during data bit 4.
    expect_frame(8'hC3, 432, -1, 1);
    write(8'hC3, 3'd7, 1'b1);
    repeat (5 * 432 + 200) @(posedge clk);
    pulse_reset();
    repeat (4) @(posedge clk);

    // Fresh frame after reset.
    expect_frame(8'h81, 432, -1, 0);
    write(8'h81, 3'd7, 1'b1);
    wait_idle(6000);

    repeat (20) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
